// File: rtl/shift_sequencer.sv
// Sequencer in front of the 32-bit combinational shifter: latches a request, drives the
// shifter for one or two passes, and holds the registered result for writeback.
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             CLK,
    input  logic             N_RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   AMT,
    input  logic [2:0]       OP,
    output logic [WIDTH-1:0] SH_IN,
    output logic [SHW-1:0]   SH_SHFT,
    output logic [1:0]       SH_SEL,
    output logic             SH_ARITH,
    input  logic [WIDTH-1:0] SH_OUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS1 = 2'd1,
        S_PASS2 = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        OP_SLL    = 3'd0,
        OP_SRL    = 3'd1,
        OP_SRA    = 3'd2,
        OP_SEXT8  = 3'd3,
        OP_SEXT16 = 3'd4,
        OP_ROL    = 3'd5,
        OP_ROR    = 3'd6,
        OP_RSVD   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        SEL_LEFT   = 2'd0,
        SEL_RIGHT  = 2'd1,
        SEL_SEXT8  = 2'd2,
        SEL_SEXT16 = 2'd3
    } sel_e;

    typedef struct packed {
        logic [WIDTH-1:0] in;
        logic [SHW-1:0]   shft;
        sel_e             sel;
        logic             arith;
    } sh_ctrl_t;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [SHW-1:0]   amt_q, amt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    sh_ctrl_t         sh;
    logic             is_rotate;

    assign is_rotate = (op_q == OP_ROL) || (op_q == OP_ROR);

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        amt_d     = amt_q;
        acc_d     = acc_q;
        sh        = '0;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    a_d     = A;
                    amt_d   = AMT;
                    // The reserved encoding is folded to SLL at capture time.
                    op_d    = (op_e'(OP) == OP_RSVD) ? OP_SLL : op_e'(OP);
                    state_d = S_PASS1;
                end
            end

            S_PASS1: begin
                sh.in   = a_q;
                sh.shft = amt_q;
                case (op_q)
                    OP_SLL:    sh.sel = SEL_LEFT;
                    OP_SRL:    sh.sel = SEL_RIGHT;
                    OP_SRA: begin
                        sh.sel   = SEL_RIGHT;
                        sh.arith = 1'b1;
                    end
                    OP_SEXT8:  sh.sel = SEL_SEXT8;
                    OP_SEXT16: sh.sel = SEL_SEXT16;
                    OP_ROL:    sh.sel = SEL_LEFT;
                    OP_ROR:    sh.sel = SEL_RIGHT;
                    default:   sh.sel = SEL_LEFT;
                endcase
                acc_d   = SH_OUT;
                state_d = (is_rotate && (amt_q != '0)) ? S_PASS2 : S_DONE;
            end

            S_PASS2: begin
                // Second half of a rotate: shift the other way by (WIDTH - AMT) mod WIDTH.
                sh.in   = a_q;
                sh.shft = ~amt_q + 1'b1;
                sh.sel  = (op_q == OP_ROL) ? SEL_RIGHT : SEL_LEFT;
                acc_d   = acc_q | SH_OUT;
                state_d = S_DONE;
            end

            S_DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours, matching the hardware.
    always_ff @(posedge CLK) begin
        if (!N_RST) begin
            state_q <= S_IDLE;
            op_q    <= OP_SLL;
            a_q     <= '0;
            amt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            amt_q   <= amt_d;
            acc_q   <= acc_d;
        end
    end

    assign SH_IN    = sh.in;
    assign SH_SHFT  = sh.shft;
    assign SH_SEL   = sh.sel;
    assign SH_ARITH = sh.arith;
    assign RESULT   = acc_q;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Sequencing stage directly upstream of the 32-bit combinational shifter. It accepts shift/extend/rotate requests over a valid/ready handshake, latches the operands, and drives the shifter's IN/SHFT/SEL/ARITH inputs. It captures the shifter output and presents a registered result to writeback. The shifter has no rotate, so rotates are built from two shifter passes ORed in an accumulator.

Parameters:
WIDTH, 32, datapath width; fixed at 32 to match the shifter.
SHW, 5, shift-amount width, log2(WIDTH).

Ports:
CLK  input  1  system clock; all state updates on rising edge
N_RST  input  1  synchronous active-low reset, sampled on rising CLK
IN_VALID  input  1  request valid
IN_READY  output  1  block can accept a request
A  input  32  operand
AMT  input  5  shift amount
OP  input  3  0=SLL 1=SRL 2=SRA 3=SEXT8 4=SEXT16 5=ROL 6=ROR 7=reserved
SH_IN  output  32  to shifter IN
SH_SHFT  output  5  to shifter SHFT
SH_SEL  output  2  to shifter SEL (0 left, 1 right, 2 sext8, 3 sext16)
SH_ARITH  output  1  to shifter ARITH
SH_OUT  input  32  from shifter OUT (combinational, same cycle)
OUT_VALID  output  1  result valid
OUT_READY  input  1  consumer accepts result
RESULT  output  32  registered result

Behaviour:
- Reset is synchronous and active-low. When N_RST=0 at a rising CLK edge, the next state is IDLE, all operand/accumulator registers are 0, OUT_VALID=0 and RESULT=0. The reset is honoured in any state and aborts any in-flight op with no output.
- States: IDLE, PASS1, PASS2, DONE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID=1, latch A/AMT/OP and go to PASS1.
  - OP=7 is treated as SLL.
- PASS1 drives the shifter from the latched operands:
  - SLL: SEL=0, SHFT=AMT, ARITH=0.
  - SRL: SEL=1, ARITH=0.
  - SRA: SEL=1, ARITH=1.
  - SEXT8: SEL=2, SHFT=AMT.
  - SEXT16: SEL=3, SHFT=AMT.
  - ROL: SEL=0, SHFT=AMT.
  - ROR: SEL=1, ARITH=0, SHFT=AMT.
  - ARITH=1 only for SRA; never with SEL=0.
  - End of PASS1: ACC <= SH_OUT.
  - Next state is PASS2 if the op is ROL/ROR and AMT!=0, else DONE.
- PASS2 (rotate only):
  - SHFT=(32-AMT) mod 32, computed as the 5-bit two's complement of AMT.
  - ROL: SEL=1, ARITH=0. ROR: SEL=0.
  - End of PASS2: ACC <= ACC | SH_OUT; go to DONE.
- DONE:
  - OUT_VALID=1; RESULT=ACC, held stable.
  - On OUT_READY=1, go to IDLE.
  - IN_READY=0, so no overlap.
- Rotate by 0 takes the single-pass path: a shift by 0 passes A through, so RESULT=A.
- Outside PASS1/PASS2: SH_IN=0, SH_SHFT=0, SH_SEL=0, SH_ARITH=0. This keeps the shifter quiet and never presents left+ARITH.
- Latency, accept edge T to OUT_VALID:
  - Single-pass ops: high after edge T+1.
  - Rotates with AMT!=0: high after edge T+2.
- Throughput: one op per 3 cycles for single-pass ops and 4 for rotates, when OUT_READY=1.
- Backpressure: DONE is held indefinitely while OUT_READY=0. RESULT must not change and IN_VALID is ignored.
- Shifter timing: SH_OUT is assumed valid within one cycle of SH_* being registered-stable. The SH_* outputs are decoded from state registers only, never from IN_VALID/A.

Test Plan:
- SRA, A=0x80000000, AMT=31 -> RESULT=0xFFFFFFFF, OUT_VALID two cycles after accept; SH_ARITH=1 only in PASS1.
- ROL, A=0x80000001, AMT=4 -> PASS1 SH_SEL=0/SHFT=4, PASS2 SH_SEL=1/SHFT=28, RESULT=0x00000018, OUT_VALID three cycles after accept.
- ROR, A=0x12345678, AMT=8 -> RESULT=0x78123456. ROR with AMT=0, A=0xDEADBEEF -> RESULT=0xDEADBEEF after the single-pass latency.
- SEXT8, A=0x00000080, AMT=4 -> RESULT=0xFFFFF800. SEXT16, A=0x00008001, AMT=0 -> RESULT=0xFFFF8001.
- Backpressure: SLL, A=1, AMT=31, OUT_READY=0 for 5 cycles with a new IN_VALID pulse -> RESULT stays 0x80000000, IN_READY=0, second request not latched until after the OUT_READY handshake.
- Reset mid-op: N_RST=0 during PASS2 of a ROL -> next cycle IDLE, OUT_VALID=0, RESULT=0, IN_READY=1, SH_* all 0. The next request completes correctly.
